axi_frame_scheduler: RTL and testbench



---
 rtl/axi_frame_scheduler_if.sv | 23 ++
 rtl/axi_frame_scheduler.sv | 161 ++++++++++++++++
 tb/tb_axi_frame_scheduler.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_frame_scheduler_if.sv
// Address-channel and data-mover handshake bundle shared by the frame scheduler
// (master side) and the AXI HP port / pixel data mover (slave side).
interface axi_frame_scheduler_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wgrant;
  logic        wlast;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rlast;

  modport master (
    output awvalid, awaddr, wgrant, arvalid, araddr,
    input  awready, wlast, arready, rlast
  );

  modport slave (
    input  awvalid, awaddr, wgrant, arvalid, araddr,
    output awready, wlast, arready, rlast
  );
endinterface

// File: rtl/axi_frame_scheduler.sv
// Shares one AXI HP port between the frame-buffer write and read streams using fixed
// 16-beat bursts and ping-pong buffers. Define SCHED_STATS_EN to build the underrun counter.
module axi_frame_scheduler #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int unsigned FRAME_BURSTS = 64800,
  parameter int unsigned BURST_BYTES  = 128,
  parameter int unsigned LW           = 10,
  parameter int unsigned WR_URGENT    = 384,
  parameter int unsigned MAX_RD_OUT   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         vs_i,
  input  logic                         wen_i,
  input  logic [LW-1:0]                wr_level_i,
  input  logic [LW-1:0]                rd_space_i,
  axi_frame_scheduler_if.master        bus,
  output logic                         busy_o,
  output logic [15:0]                  stat_underrun_o
);

  localparam int IW = $clog2(FRAME_BURSTS + 1);
  localparam int OW = $clog2(MAX_RD_OUT + 1);
  localparam int SH = $clog2(BURST_BYTES);
  localparam logic [31:0]   BUF_BYTES = 32'(FRAME_BURSTS * BURST_BYTES);
  localparam logic [IW-1:0] IDX_MAX   = IW'(FRAME_BURSTS);

  typedef enum logic [1:0] {IDLE, AW, WDATA, AR} state_t;

  state_t        state;
  state_t        state_next;
  logic          wbuf;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [OW-1:0] rd_out;
  logic          last_wr;
  logic          vs_q;
  logic          vs_pend;
  logic          wgrant_q;
  logic [31:0]   awaddr_q;
  logic [31:0]   araddr_q;

  logic          we;
  logic          re;
  logic          grant_wr;
  logic          grant_rd;
  logic          apply_vs;
  logic          aw_hs;
  logic          ar_hs;
  logic          rd_dec;
  logic [31:0]   rd_need;
  logic [31:0]   wr_addr;
  logic [31:0]   rd_addr;

  // A read is only issued when the read FIFO can absorb every burst already in flight plus this one.
  always_comb begin
    rd_need  = (32'(rd_out) + 32'd1) << 4;
    apply_vs = (state == IDLE) && vs_pend;
    aw_hs    = (state == AW) && bus.awready;
    ar_hs    = (state == AR) && bus.arready;
    rd_dec   = bus.rlast && (rd_out != '0);
    we = wen_i && (32'(wr_level_i) >= 32'd16) && (wr_idx < IDX_MAX);
    re = (32'(rd_space_i) >= rd_need) && (rd_idx < IDX_MAX) &&
         (32'(rd_out) < 32'(MAX_RD_OUT));
    wr_addr = BASE_ADDR + (wbuf ? BUF_BYTES : 32'd0) + (32'(wr_idx) << SH);
    rd_addr = BASE_ADDR + (wbuf ? 32'd0 : BUF_BYTES) + (32'(rd_idx) << SH);
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if ((state == IDLE) && !vs_pend) begin
      if (we && re) begin
        if ((32'(wr_level_i) >= 32'(WR_URGENT)) || !last_wr) grant_wr = 1'b1;
        else                                                 grant_rd = 1'b1;
      end else if (we) begin
        grant_wr = 1'b1;
      end else if (re) begin
        grant_rd = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_wr)      state_next = AW;
               else if (grant_rd) state_next = AR;
      AW:      if (bus.awready)   state_next = WDATA;
      WDATA:   if (bus.wlast)     state_next = IDLE;
      AR:      if (bus.arready)   state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.awvalid = (state == AW);
    bus.arvalid = (state == AR);
    bus.awaddr  = awaddr_q;
    bus.araddr  = araddr_q;
    bus.wgrant  = wgrant_q;
    busy_o      = (state != IDLE);
  end

  // Frame swaps wait for IDLE so an in-flight burst always finishes at its latched address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wbuf     <= 1'b0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      rd_out   <= '0;
      last_wr  <= 1'b0;
      vs_q     <= 1'b0;
      vs_pend  <= 1'b0;
      wgrant_q <= 1'b0;
      awaddr_q <= 32'd0;
      araddr_q <= 32'd0;
    end else begin
      vs_q     <= vs_i;
      vs_pend  <= (vs_pend && !apply_vs) || (vs_i && !vs_q);
      wgrant_q <= aw_hs;
      if (apply_vs) begin
        wr_idx <= '0;
        rd_idx <= '0;
        if (wen_i) wbuf <= ~wbuf;
      end
      if (grant_wr) begin
        awaddr_q <= wr_addr;
        last_wr  <= 1'b1;
      end
      if (grant_rd) begin
        araddr_q <= rd_addr;
        last_wr  <= 1'b0;
      end
      if (aw_hs && (wr_idx < IDX_MAX)) wr_idx <= wr_idx + IW'(1);
      if (ar_hs && (rd_idx < IDX_MAX)) rd_idx <= rd_idx + IW'(1);
      if (ar_hs && !rd_dec)      rd_out <= rd_out + OW'(1);
      else if (rd_dec && !ar_hs) rd_out <= rd_out - OW'(1);
    end
  end

`ifdef SCHED_STATS_EN
  logic [15:0] stat_cnt;

  // Counts frames whose read stream had not finished when the boundary was taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_cnt <= 16'd0;
    end else if (apply_vs && (rd_idx < IDX_MAX) && (stat_cnt != 16'hFFFF)) begin
      stat_cnt <= stat_cnt + 16'd1;
    end
  end

  assign stat_underrun_o = stat_cnt;
`else
  assign stat_underrun_o = 16'd0;
`endif

endmodule

// File: tb/tb_axi_frame_scheduler.sv
// Directed bench for axi_frame_scheduler with a 4-burst frame, base 0 and two outstanding reads.
module tb_axi_frame_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        vs_i;
  logic        wen_i;
  logic [9:0]  wr_level_i;
  logic [9:0]  rd_space_i;
  logic        busy_o;
  logic [15:0] stat_underrun_o;

  axi_frame_scheduler_if bus ();

  axi_frame_scheduler #(
    .BASE_ADDR    (32'h0),
    .FRAME_BURSTS (4),
    .BURST_BYTES  (128),
    .LW           (10),
    .WR_URGENT    (384),
    .MAX_RD_OUT   (2)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .vs_i            (vs_i),
    .wen_i           (wen_i),
    .wr_level_i      (wr_level_i),
    .rd_space_i      (rd_space_i),
    .bus             (bus),
    .busy_o          (busy_o),
    .stat_underrun_o (stat_underrun_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef SCHED_STATS_EN
  localparam logic [31:0] STAT_EXP = 32'd1;
`else
  localparam logic [31:0] STAT_EXP = 32'd0;
`endif

  int          n_compared   = 0;
  int          n_mismatched = 0;
  logic        g_kind [8];
  logic [31:0] g_addr [8];
  int          g_count;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic wen, input logic [9:0] wr_level, input logic [9:0] rd_space);
    wen_i      = wen;
    wr_level_i = wr_level;
    rd_space_i = rd_space;
  endtask

  task automatic wait_aw(input string tag, input logic [31:0] exp);
    int n = 0;
    while (!bus.awvalid && n < 30) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput({tag, "_seen"}, 32'(bus.awvalid), 32'd1);
    checkOutput(tag, bus.awaddr, exp);
  endtask

  task automatic wait_ar(input string tag, input logic [31:0] exp);
    int n = 0;
    while (!bus.arvalid && n < 30) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput({tag, "_seen"}, 32'(bus.arvalid), 32'd1);
    checkOutput(tag, bus.araddr, exp);
  endtask

  task automatic finish_wr(input string tag);
    @(negedge clk_i);
    checkOutput(tag, 32'(bus.wgrant), 32'd1);
    bus.wlast = 1'b1;
    @(negedge clk_i);
    bus.wlast = 1'b0;
  endtask

  task automatic pulse_rlast();
    bus.rlast = 1'b1;
    @(negedge clk_i);
    bus.rlast = 1'b0;
  endtask

  task automatic pulse_vs();
    vs_i = 1'b1;
    @(negedge clk_i);
    vs_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic count_ar(input int cycles, output int cnt, output logic [31:0] first);
    cnt   = 0;
    first = 32'hFFFF_FFFF;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk_i);
      if (bus.arvalid && bus.arready) begin
        if (cnt == 0) first = bus.araddr;
        cnt++;
      end
    end
  endtask

  // Records the next n address grants while acting as the data mover for any write bursts.
  task automatic run_grants(input int n);
    g_count = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk_i);
      if (bus.wlast)  bus.wlast = 1'b0;
      if (bus.wgrant) bus.wlast = 1'b1;
      if (g_count < n) begin
        if (bus.awvalid) begin
          g_kind[g_count] = 1'b1;
          g_addr[g_count] = bus.awaddr;
          g_count++;
        end else if (bus.arvalid) begin
          g_kind[g_count] = 1'b0;
          g_addr[g_count] = bus.araddr;
          g_count++;
        end
        if (g_count == n) begin
          wr_level_i = 10'd0;
          rd_space_i = 10'd0;
        end
      end
    end
    checkOutput("grant_count", 32'(g_count), 32'(n));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        rr_kind [4];
    logic [31:0] rr_addr [4];
    int          cnt;
    logic [31:0] first;

    rst_ni      = 1'b0;
    vs_i        = 1'b0;
    bus.awready = 1'b0;
    bus.arready = 1'b0;
    bus.wlast   = 1'b0;
    bus.rlast   = 1'b0;
    applyStimulus(1'b0, 10'd0, 10'd0);
    repeat (3) @(negedge clk_i);
    checkOutput("rst_awvalid", 32'(bus.awvalid), 32'd0);
    checkOutput("rst_arvalid", 32'(bus.arvalid), 32'd0);
    checkOutput("rst_awaddr",  bus.awaddr, 32'd0);
    checkOutput("rst_araddr",  bus.araddr, 32'd0);
    checkOutput("rst_wgrant",  32'(bus.wgrant), 32'd0);
    checkOutput("rst_busy",    32'(busy_o), 32'd0);
    checkOutput("rst_stat",    32'(stat_underrun_o), 32'd0);
    rst_ni = 1'b1;

    $display("[TB] write path, buffer 0");
    bus.awready = 1'b1;
    bus.arready = 1'b1;
    applyStimulus(1'b1, 10'd16, 10'd0);
    for (int i = 0; i < 4; i++) begin
      wait_aw($sformatf("wr_aw%0d", i), 32'(i * 128));
      finish_wr($sformatf("wr_wgrant%0d", i));
    end
    cnt = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (bus.awvalid) cnt++;
    end
    checkOutput("no_5th_aw", 32'(cnt), 32'd0);

    $display("[TB] buffer swap");
    pulse_vs();
    wait_aw("swap_aw", 32'h200);
    finish_wr("swap_wgrant");
    applyStimulus(1'b1, 10'd0, 10'd64);
    wait_ar("first_ar", 32'h000);
    rd_space_i = 10'd0;
    @(negedge clk_i);
    pulse_rlast();

    $display("[TB] round robin and urgency");
    pulse_vs();
    applyStimulus(1'b1, 10'd100, 10'd64);
    run_grants(4);
    rr_kind = '{1'b1, 1'b0, 1'b1, 1'b0};
    rr_addr = '{32'h000, 32'h200, 32'h080, 32'h280};
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr_kind%0d", i), 32'(g_kind[i]), 32'(rr_kind[i]));
      checkOutput($sformatf("rr_addr%0d", i), g_addr[i], rr_addr[i]);
    end
    pulse_rlast();
    pulse_rlast();
    applyStimulus(1'b1, 10'd400, 10'd64);
    run_grants(2);
    checkOutput("urg_kind0", 32'(g_kind[0]), 32'd1);
    checkOutput("urg_addr0", g_addr[0], 32'h100);
    checkOutput("urg_kind1", 32'(g_kind[1]), 32'd1);
    checkOutput("urg_addr1", g_addr[1], 32'h180);

    $display("[TB] read outstanding limit");
    applyStimulus(1'b0, 10'd0, 10'd0);
    pulse_vs();
    rd_space_i = 10'd64;
    count_ar(20, cnt, first);
    checkOutput("rdlim_count", 32'(cnt), 32'd2);
    checkOutput("rdlim_first", first, 32'h200);
    pulse_rlast();
    count_ar(10, cnt, first);
    checkOutput("rdlim_third_count", 32'(cnt), 32'd1);
    checkOutput("rdlim_third_addr", first, 32'h300);
    rd_space_i = 10'd0;
    pulse_rlast();
    pulse_rlast();

    $display("[TB] backpressure and mid-burst vs");
    bus.awready = 1'b0;
    applyStimulus(1'b1, 10'd16, 10'd0);
    wait_aw("bp_aw", 32'h000);
    cnt = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (bus.awvalid && bus.awaddr == 32'h000) cnt++;
    end
    checkOutput("bp_stable", 32'(cnt), 32'd5);
    bus.awready = 1'b1;
    @(negedge clk_i);
    checkOutput("bp_wgrant", 32'(bus.wgrant), 32'd1);
    checkOutput("bp_awvalid_drop", 32'(bus.awvalid), 32'd0);
    vs_i = 1'b1;
    @(negedge clk_i);
    vs_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("mid_busy", 32'(busy_o), 32'd1);
    checkOutput("mid_awvalid", 32'(bus.awvalid), 32'd0);
    bus.wlast = 1'b1;
    @(negedge clk_i);
    bus.wlast = 1'b0;
    wait_aw("swap_after_wlast", 32'h200);
    @(negedge clk_i);
    checkOutput("swap_after_wgrant", 32'(bus.wgrant), 32'd1);
    wen_i = 1'b0;
    vs_i  = 1'b1;
    @(negedge clk_i);
    vs_i = 1'b0;
    repeat (2) @(negedge clk_i);
    bus.wlast = 1'b1;
    @(negedge clk_i);
    bus.wlast = 1'b0;
    repeat (3) @(negedge clk_i);
    wen_i = 1'b1;
    wait_aw("wen0_keep", 32'h200);
    finish_wr("wen0_wgrant");
    applyStimulus(1'b0, 10'd0, 10'd0);

    $display("[TB] underrun stats and async reset");
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    checkOutput("rst2_stat", 32'(stat_underrun_o), 32'd0);
    rst_ni = 1'b1;
    applyStimulus(1'b0, 10'd0, 10'd64);
    count_ar(20, cnt, first);
    checkOutput("stat_reads", 32'(cnt), 32'd2);
    rd_space_i = 10'd0;
    pulse_vs();
    checkOutput("stat_underrun", 32'(stat_underrun_o), STAT_EXP);
    bus.arready = 1'b0;
    rd_space_i  = 10'd64;
    pulse_rlast();
    wait_ar("rst_ar", 32'h200);
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("async_arvalid", 32'(bus.arvalid), 32'd0);
    checkOutput("async_busy", 32'(busy_o), 32'd0);
    checkOutput("async_araddr", bus.araddr, 32'd0);
    checkOutput("async_stat", 32'(stat_underrun_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
